// File: rtl/padctl_strap.sv
`default_nettype none
// ============================================================================
// Module   : padctl_strap
// Desc     : FPGA pad controller: GPIO sync/filter, boot-strap lock and
//            JTAG/SPI debug pin steering. Macro PADCTL_GLITCH_FILTER_EN
//            enables the per-channel GPIO glitch filters.
// Revision : 1.0 - initial release
// ============================================================================
module padctl_strap #(
    parameter int unsigned NumGpio         = 16,
    parameter int unsigned FilterCycles    = 4,
    parameter int unsigned StrapHoldCycles = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NumGpio-1:0] gpio_pad_i,
    output logic [NumGpio-1:0] gpio_pad_o,
    output logic [NumGpio-1:0] gpio_pad_oe_o,
    output logic [NumGpio-1:0] cio_gpio_p2d_o,
    input  logic [NumGpio-1:0] cio_gpio_d2p_i,
    input  logic [NumGpio-1:0] cio_gpio_en_d2p_i,
    input  logic [1:0]         strap_i,
    output logic [1:0]         strap_o,
    output logic               strap_valid_o,
    input  logic [2:0]         dps_i,
    output logic               dps_o,
    output logic               dps_oe_o,
    output logic               jtag_tck_o,
    output logic               jtag_tms_o,
    output logic               jtag_tdi_o,
    input  logic               jtag_tdo_i,
    output logic               spi_sck_o,
    output logic               spi_csb_o,
    output logic               spi_mosi_o,
    input  logic               spi_miso_i,
    input  logic               spi_miso_en_i
);

    localparam int unsigned    SCW        = (StrapHoldCycles > 1) ? $clog2(StrapHoldCycles) : 1;
    localparam logic [SCW-1:0] STRAP_LAST = SCW'(StrapHoldCycles - 1);
    localparam logic [2:0]     DPS_RST    = 3'b010;
    localparam logic [0:0]     ST_SAMPLE  = 1'b0;
    localparam logic [0:0]     ST_LOCKED  = 1'b1;

    logic [NumGpio-1:0] gpio_s1_q, gpio_s1_d, gpio_s2_q, gpio_s2_d;
    logic [NumGpio-1:0] pad_out_q, pad_out_d, pad_oe_q, pad_oe_d;
    logic [1:0]         strap_s1_q, strap_s1_d, strap_s2_q, strap_s2_d;
    logic [2:0]         dps_s1_q, dps_s1_d, dps_s2_q, dps_s2_d;
    logic [0:0]         state_q, state_d;
    logic [SCW-1:0]     strap_cnt_q, strap_cnt_d;
    logic [1:0]         strap_prev_q, strap_prev_d;
    logic [1:0]         strap_lock_q, strap_lock_d;

    always_comb begin
        gpio_s1_d  = gpio_pad_i;
        gpio_s2_d  = gpio_s1_q;
        strap_s1_d = strap_i;
        strap_s2_d = strap_s1_q;
        dps_s1_d   = dps_i;
        dps_s2_d   = dps_s1_q;
        pad_out_d  = cio_gpio_d2p_i;
        pad_oe_d   = cio_gpio_en_d2p_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gpio_s1_q  <= '0;
            gpio_s2_q  <= '0;
            strap_s1_q <= '0;
            strap_s2_q <= '0;
            dps_s1_q   <= DPS_RST;
            dps_s2_q   <= DPS_RST;
            pad_out_q  <= '0;
            pad_oe_q   <= '0;
        end else begin
            gpio_s1_q  <= gpio_s1_d;
            gpio_s2_q  <= gpio_s2_d;
            strap_s1_q <= strap_s1_d;
            strap_s2_q <= strap_s2_d;
            dps_s1_q   <= dps_s1_d;
            dps_s2_q   <= dps_s2_d;
            pad_out_q  <= pad_out_d;
            pad_oe_q   <= pad_oe_d;
        end
    end

    // Strap FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_SAMPLE;
            strap_cnt_q  <= '0;
            strap_prev_q <= '0;
            strap_lock_q <= '0;
        end else begin
            state_q      <= state_d;
            strap_cnt_q  <= strap_cnt_d;
            strap_prev_q <= strap_prev_d;
            strap_lock_q <= strap_lock_d;
        end
    end

    // Straps are compared as they enter the last synchroniser stage, so a change
    // restarts the hold count on the edge it leaves the synchroniser.
    always_comb begin
        state_d      = state_q;
        strap_cnt_d  = strap_cnt_q;
        strap_prev_d = strap_prev_q;
        strap_lock_d = strap_lock_q;
        if (state_q == ST_SAMPLE) begin
            if (strap_s1_q != strap_prev_q) begin
                strap_cnt_d  = '0;
                strap_prev_d = strap_s1_q;
            end else if (strap_cnt_q == STRAP_LAST) begin
                strap_lock_d = strap_s2_q;
                state_d      = ST_LOCKED;
            end else begin
                strap_cnt_d = strap_cnt_q + SCW'(1);
            end
        end
    end

    always_comb begin
        strap_valid_o = (state_q == ST_LOCKED);
        jtag_tck_o    = 1'b0;
        jtag_tms_o    = 1'b1;
        jtag_tdi_o    = 1'b0;
        spi_sck_o     = 1'b0;
        spi_csb_o     = 1'b1;
        spi_mosi_o    = 1'b0;
        dps_o         = 1'b0;
        dps_oe_o      = 1'b0;
        if (state_q == ST_LOCKED) begin
            if (strap_lock_q[0]) begin
                spi_sck_o  = dps_s2_q[0];
                spi_csb_o  = dps_s2_q[1];
                spi_mosi_o = dps_s2_q[2];
                dps_o      = spi_miso_i;
                dps_oe_o   = spi_miso_en_i;
            end else begin
                jtag_tck_o = dps_s2_q[0];
                jtag_tms_o = dps_s2_q[1];
                jtag_tdi_o = dps_s2_q[2];
                dps_o      = jtag_tdo_i;
                dps_oe_o   = 1'b1;
            end
        end
    end

    assign strap_o       = strap_lock_q;
    assign gpio_pad_o    = pad_out_q;
    assign gpio_pad_oe_o = pad_oe_q;

`ifdef PADCTL_GLITCH_FILTER_EN
    localparam int unsigned FCW = $clog2(FilterCycles + 1);

    for (genvar g = 0; g < NumGpio; g++) begin : g_filter
        logic           filt_q, filt_d;
        logic [FCW-1:0] fcnt_q, fcnt_d;

        always_comb begin
            filt_d = filt_q;
            fcnt_d = '0;
            if (gpio_s2_q[g] != filt_q) begin
                if (fcnt_q == FCW'(FilterCycles - 1)) begin
                    filt_d = gpio_s2_q[g];
                end else begin
                    fcnt_d = fcnt_q + FCW'(1);
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                filt_q <= 1'b0;
                fcnt_q <= '0;
            end else begin
                filt_q <= filt_d;
                fcnt_q <= fcnt_d;
            end
        end

        assign cio_gpio_p2d_o[g] = filt_q;
    end
`else
    // An illegal FilterCycles ties the bank off instead of hiding the misconfiguration.
    if (FilterCycles >= 1) begin : g_bypass
        assign cio_gpio_p2d_o = gpio_s2_q;
    end else begin : g_bypass_bad_cfg
        assign cio_gpio_p2d_o = '0;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_padctl_strap.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_padctl_strap
// Desc     : Self-checking bench for padctl_strap (vector tables + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_padctl_strap;

    localparam int unsigned NUM_GPIO      = 16;
    localparam int unsigned FILTER_CYCLES = 4;
    localparam int unsigned STRAP_HOLD    = 16;
`ifdef PADCTL_GLITCH_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif
    localparam int unsigned GPIO_LAT = FILTER_ON ? FILTER_CYCLES + 2 : 2;
    localparam int unsigned LOCK_EDGE = STRAP_HOLD + 2;

    logic                clk;
    logic                rst_i;
    logic [NUM_GPIO-1:0] gpio_pad_i, gpio_pad_o, gpio_pad_oe_o, cio_gpio_p2d_o;
    logic [NUM_GPIO-1:0] cio_gpio_d2p_i, cio_gpio_en_d2p_i;
    logic [1:0]          strap_i, strap_o;
    logic                strap_valid_o;
    logic [2:0]          dps_i;
    logic                dps_o, dps_oe_o;
    logic                jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_tdo_i;
    logic                spi_sck_o, spi_csb_o, spi_mosi_o, spi_miso_i, spi_miso_en_i;

    padctl_strap #(
        .NumGpio        (NUM_GPIO),
        .FilterCycles   (FILTER_CYCLES),
        .StrapHoldCycles(STRAP_HOLD)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .gpio_pad_i       (gpio_pad_i),
        .gpio_pad_o       (gpio_pad_o),
        .gpio_pad_oe_o    (gpio_pad_oe_o),
        .cio_gpio_p2d_o   (cio_gpio_p2d_o),
        .cio_gpio_d2p_i   (cio_gpio_d2p_i),
        .cio_gpio_en_d2p_i(cio_gpio_en_d2p_i),
        .strap_i          (strap_i),
        .strap_o          (strap_o),
        .strap_valid_o    (strap_valid_o),
        .dps_i            (dps_i),
        .dps_o            (dps_o),
        .dps_oe_o         (dps_oe_o),
        .jtag_tck_o       (jtag_tck_o),
        .jtag_tms_o       (jtag_tms_o),
        .jtag_tdi_o       (jtag_tdi_o),
        .jtag_tdo_i       (jtag_tdo_i),
        .spi_sck_o        (spi_sck_o),
        .spi_csb_o        (spi_csb_o),
        .spi_mosi_o       (spi_mosi_o),
        .spi_miso_i       (spi_miso_i),
        .spi_miso_en_i    (spi_miso_en_i)
    );

    typedef struct {
        logic [15:0] d2p;
        logic [15:0] en;
        logic [15:0] exp_pad;
        logic [15:0] exp_oe;
    } gout_vec_t;

    // exp_jtag = {tdi, tms, tck}, exp_spi = {mosi, csb, sck}
    typedef struct {
        logic [2:0] dps;
        logic       tdo;
        logic       miso;
        logic       miso_en;
        logic [2:0] exp_jtag;
        logic [2:0] exp_spi;
        logic       exp_do;
        logic       exp_oe;
    } dbg_vec_t;

    gout_vec_t gout_tbl[4];
    dbg_vec_t  jtag_tbl[3];
    dbg_vec_t  spi_tbl[3];
    gout_vec_t gout_q[$];
    dbg_vec_t  dbg_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_gout(input gout_vec_t v);
        gout_vec_t e;
        cio_gpio_d2p_i    = v.d2p;
        cio_gpio_en_d2p_i = v.en;
        gout_q.push_back(v);
        tick(1);
        e = gout_q.pop_front();
        check("gpio_pad_o", gpio_pad_o, e.exp_pad);
        check("gpio_pad_oe_o", gpio_pad_oe_o, e.exp_oe);
    endtask

    task automatic run_dbg(input string tag, input dbg_vec_t v);
        dbg_vec_t e;
        dps_i         = v.dps;
        jtag_tdo_i    = v.tdo;
        spi_miso_i    = v.miso;
        spi_miso_en_i = v.miso_en;
        dbg_q.push_back(v);
        tick(2);
        e = dbg_q.pop_front();
        check({tag, "_jtag"}, {jtag_tdi_o, jtag_tms_o, jtag_tck_o}, e.exp_jtag);
        check({tag, "_spi"}, {spi_mosi_o, spi_csb_o, spi_sck_o}, e.exp_spi);
        check({tag, "_dps_o"}, dps_o, e.exp_do);
        check({tag, "_dps_oe"}, dps_oe_o, e.exp_oe);
    endtask

    initial begin
        gout_tbl[0] = '{16'hA5A5, 16'hFF00, 16'hA5A5, 16'hFF00};
        gout_tbl[1] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        gout_tbl[2] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        gout_tbl[3] = '{16'h1234, 16'h8001, 16'h1234, 16'h8001};

        jtag_tbl[0] = '{3'b101, 1'b1, 1'b0, 1'b0, 3'b101, 3'b010, 1'b1, 1'b1};
        jtag_tbl[1] = '{3'b010, 1'b0, 1'b1, 1'b1, 3'b010, 3'b010, 1'b0, 1'b1};
        jtag_tbl[2] = '{3'b111, 1'b1, 1'b1, 1'b0, 3'b111, 3'b010, 1'b1, 1'b1};

        spi_tbl[0]  = '{3'b011, 1'b1, 1'b1, 1'b1, 3'b010, 3'b011, 1'b1, 1'b1};
        spi_tbl[1]  = '{3'b100, 1'b0, 1'b1, 1'b0, 3'b010, 3'b100, 1'b1, 1'b0};
        spi_tbl[2]  = '{3'b001, 1'b1, 1'b0, 1'b1, 3'b010, 3'b001, 1'b0, 1'b1};

        // Reset with every input driven non-idle.
        rst_i             = 1'b1;
        gpio_pad_i        = 16'hFFFF;
        cio_gpio_d2p_i    = 16'hA5A5;
        cio_gpio_en_d2p_i = 16'hFF00;
        strap_i           = 2'b10;
        dps_i             = 3'b111;
        jtag_tdo_i        = 1'b1;
        spi_miso_i        = 1'b1;
        spi_miso_en_i     = 1'b1;
        tick(3);
        check("rst_p2d", cio_gpio_p2d_o, 0);
        check("rst_pad_o", gpio_pad_o, 0);
        check("rst_pad_oe", gpio_pad_oe_o, 0);
        check("rst_strap_o", strap_o, 0);
        check("rst_valid", strap_valid_o, 0);
        check("rst_dps", {dps_oe_o, dps_o}, 0);
        check("rst_jtag", {jtag_tdi_o, jtag_tms_o, jtag_tck_o}, 3'b010);
        check("rst_spi", {spi_mosi_o, spi_csb_o, spi_sck_o}, 3'b010);

        // JTAG lock with constant straps.
        rst_i             = 1'b0;
        gpio_pad_i        = '0;
        cio_gpio_d2p_i    = '0;
        cio_gpio_en_d2p_i = '0;
        dps_i             = 3'b000;
        for (int e = 1; e <= LOCK_EDGE; e++) begin
            tick(1);
            if (e == LOCK_EDGE - 1) begin
                check("prelock_valid", strap_valid_o, 0);
                check("prelock_jtag_idle", {jtag_tdi_o, jtag_tms_o, jtag_tck_o}, 3'b010);
                check("prelock_dps_oe", dps_oe_o, 0);
            end
            if (e == LOCK_EDGE) begin
                check("jtag_lock_valid", strap_valid_o, 1);
                check("jtag_lock_strap", strap_o, 2'b10);
            end
        end

        // GPIO output registers.
        for (int i = 0; i < 4; i++) run_gout(gout_tbl[i]);

        // GPIO input latency on bit 3.
        gpio_pad_i = 16'h0008;
        tick(GPIO_LAT - 1);
        check("gpio3_early", cio_gpio_p2d_o[3], 0);
        tick(1);
        check("gpio3_arrive", cio_gpio_p2d_o[3], 1);

        // Three-cycle pulse on bit 5.
        for (int j = 1; j <= 10; j++) begin
            gpio_pad_i = (j <= 3) ? 16'h0028 : 16'h0008;
            tick(1);
            check("glitch_bit5", cio_gpio_p2d_o[5], FILTER_ON ? 1'b0 : ((j >= 2) && (j <= 4)));
            check("glitch_bit3", cio_gpio_p2d_o[3], 1);
        end

        // JTAG debug path: two-cycle synchroniser then table.
        dps_i = 3'b101;
        tick(1);
        check("jtag_sync_1cyc", {jtag_tdi_o, jtag_tms_o, jtag_tck_o}, 3'b000);
        tick(1);
        check("jtag_sync_2cyc", {jtag_tdi_o, jtag_tms_o, jtag_tck_o}, 3'b101);
        for (int i = 0; i < 3; i++) run_dbg("jtag", jtag_tbl[i]);

        strap_i = 2'b01;
        tick(5);
        check("jtag_strap_held", strap_o, 2'b10);
        check("jtag_valid_held", strap_valid_o, 1);

        // Strap bounce into SPI mode.
        rst_i   = 1'b1;
        strap_i = 2'b01;
        tick(2);
        rst_i = 1'b0;
        for (int e = 1; e <= 28; e++) begin
            if (e == 6) strap_i = 2'b00;
            if (e == 11) strap_i = 2'b01;
            tick(1);
            if (e == LOCK_EDGE || e == 27) check("bounce_not_locked", strap_valid_o, 0);
            if (e == 28) begin
                check("bounce_locked", strap_valid_o, 1);
                check("bounce_strap", strap_o, 2'b01);
            end
        end

        for (int i = 0; i < 3; i++) run_dbg("spi", spi_tbl[i]);

        strap_i = 2'b10;
        tick(5);
        check("spi_strap_held", strap_o, 2'b01);

        // Reset while locked in SPI mode.
        dps_i         = 3'b000;
        spi_miso_en_i = 1'b1;
        tick(2);
        check("spi_csb_active", spi_csb_o, 0);
        check("spi_oe_active", dps_oe_o, 1);
        rst_i = 1'b1;
        tick(1);
        check("midrst_valid", strap_valid_o, 0);
        check("midrst_csb", spi_csb_o, 1);
        check("midrst_oe", dps_oe_o, 0);
        check("midrst_strap", strap_o, 0);
        rst_i = 1'b0;
        for (int e = 1; e <= LOCK_EDGE; e++) begin
            tick(1);
            if (e == LOCK_EDGE - 1) check("relock_early", strap_valid_o, 0);
            if (e == LOCK_EDGE) begin
                check("relock_valid", strap_valid_o, 1);
                check("relock_strap", strap_o, 2'b10);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
